// File: rtl/sobel_edge_3x3.sv
// Sobel gradient-magnitude and edge-detect stage.
// Consumes one 3x3 window per valid cycle, tracks the raster position of the
// window centre, and emits a 3-stage pipelined, position-tagged magnitude
// stream with frame/line markers. Border centres are forced to zero.
// The edge output is named edge_flag because "edge" is a reserved word.
module sobel_edge_3x3 #(
    parameter int          IMG_W  = 64,
    parameter int          IMG_H  = 64,
    parameter logic [7:0]  THRESH = 8'd128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] win0,
    input  logic [7:0] win1,
    input  logic [7:0] win2,
    input  logic [7:0] win3,
    input  logic [7:0] win4,
    input  logic [7:0] win5,
    input  logic [7:0] win6,
    input  logic [7:0] win7,
    input  logic [7:0] win8,
    input  logic       win_valid,
    input  logic       win_sof,
    output logic [7:0] mag,
    output logic       edge_flag,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eol,
    output logic       out_eof,
    output logic       frame_err
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    // Two's-complement absolute value of an 11-bit gradient (|-1020| fits).
    function automatic logic [10:0] abs11(input logic [10:0] v);
        return v[10] ? (11'd0 - v) : v;
    endfunction

    state_t        state_r, state_s;
    logic [CW-1:0] col_r, col_s, pos_col_s;
    logic [RW-1:0] row_r, row_s, pos_row_s;
    logic          accept_s, err_set_s;
    logic          first_s, eol_s, eof_s, border_s;
    logic [10:0]   gx_s, gy_s;

    logic          v1_r, b1_r, sof1_r, eol1_r, eof1_r;
    logic [10:0]   gx_r, gy_r;
    logic          v2_r, b2_r, sof2_r, eol2_r, eof2_r;
    logic [10:0]   sum_r;
    logic [7:0]    mag_s;
    logic          edge_s;

    // Decide whether this window is accepted, where its centre sits, and
    // where the raster counters go next. A sof window always restarts at (0,0).
    always_comb begin
        state_s   = state_r;
        col_s     = col_r;
        row_s     = row_r;
        pos_col_s = col_r;
        pos_row_s = row_r;
        accept_s  = 1'b0;
        err_set_s = 1'b0;
        if (win_valid) begin
            if (win_sof) begin
                accept_s  = 1'b1;
                pos_col_s = {CW{1'b0}};
                pos_row_s = {RW{1'b0}};
                err_set_s = (state_r == ACTIVE);
            end else if (state_r == ACTIVE) begin
                accept_s = 1'b1;
            end else begin
                accept_s = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
        end
        if (accept_s) begin
            if ((pos_col_s == COL_LAST) && (pos_row_s == ROW_LAST)) begin
                state_s = IDLE;
                col_s   = {CW{1'b0}};
                row_s   = {RW{1'b0}};
            end else if (pos_col_s == COL_LAST) begin
                state_s = ACTIVE;
                col_s   = {CW{1'b0}};
                row_s   = pos_row_s + {{(RW-1){1'b0}}, 1'b1};
            end else begin
                state_s = ACTIVE;
                col_s   = pos_col_s + {{(CW-1){1'b0}}, 1'b1};
                row_s   = pos_row_s;
            end
        end else begin
            state_s = state_r;
        end
    end

    // Position-derived markers/border flag and the raw Sobel gradients.
    always_comb begin
        first_s  = (pos_col_s == {CW{1'b0}}) && (pos_row_s == {RW{1'b0}});
        eol_s    = (pos_col_s == COL_LAST);
        eof_s    = (pos_col_s == COL_LAST) && (pos_row_s == ROW_LAST);
        border_s = (pos_col_s == {CW{1'b0}}) || (pos_col_s == COL_LAST) ||
                   (pos_row_s == {RW{1'b0}}) || (pos_row_s == ROW_LAST);
        gx_s = ({3'b000, win2} + {2'b00, win5, 1'b0} + {3'b000, win8}) -
               ({3'b000, win0} + {2'b00, win3, 1'b0} + {3'b000, win6});
        gy_s = ({3'b000, win6} + {2'b00, win7, 1'b0} + {3'b000, win8}) -
               ({3'b000, win0} + {2'b00, win1, 1'b0} + {3'b000, win2});
    end

    // FSM state, raster counters and sticky frame error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            col_r     <= {CW{1'b0}};
            row_r     <= {RW{1'b0}};
            frame_err <= 1'b0;
        end else begin
            state_r   <= state_s;
            col_r     <= col_s;
            row_r     <= row_s;
            frame_err <= frame_err | err_set_s;
        end
    end

    // Stage 1: gradients, border flag and markers.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r   <= 1'b0;
            gx_r   <= 11'd0;
            gy_r   <= 11'd0;
            b1_r   <= 1'b0;
            sof1_r <= 1'b0;
            eol1_r <= 1'b0;
            eof1_r <= 1'b0;
        end else begin
            v1_r   <= accept_s;
            gx_r   <= gx_s;
            gy_r   <= gy_s;
            b1_r   <= border_s;
            sof1_r <= accept_s & first_s;
            eol1_r <= accept_s & eol_s;
            eof1_r <= accept_s & eof_s;
        end
    end

    // Stage 2: |Gx| + |Gy|.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r   <= 1'b0;
            sum_r  <= 11'd0;
            b2_r   <= 1'b0;
            sof2_r <= 1'b0;
            eol2_r <= 1'b0;
            eof2_r <= 1'b0;
        end else begin
            v2_r   <= v1_r;
            sum_r  <= abs11(gx_r) + abs11(gy_r);
            b2_r   <= b1_r;
            sof2_r <= sof1_r;
            eol2_r <= eol1_r;
            eof2_r <= eof1_r;
        end
    end

    // Saturation, border forcing and threshold ahead of the output registers.
    always_comb begin
        if (b2_r) begin
            mag_s = 8'd0;
        end else if (sum_r > 11'd255) begin
            mag_s = 8'd255;
        end else begin
            mag_s = sum_r[7:0];
        end
        edge_s = ~b2_r & (mag_s >= THRESH);
    end

    // Stage 3: output registers; markers and edge never high on a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            mag       <= 8'd0;
            edge_flag <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= v2_r;
            mag       <= v2_r ? mag_s : 8'd0;
            edge_flag <= v2_r & edge_s;
            out_sof   <= v2_r & sof2_r;
            out_eol   <= v2_r & eol2_r;
            out_eof   <= v2_r & eof2_r;
        end
    end

endmodule

// File: tb/tb_sobel_edge_3x3.sv
// Directed self-checking bench for sobel_edge_3x3 (64x64, THRESH=128).
module tb_sobel_edge_3x3;

    localparam int W = 64;
    localparam int H = 64;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] w0 = 8'd0, w1 = 8'd0, w2 = 8'd0, w3 = 8'd0, w4 = 8'd0;
    logic [7:0] w5 = 8'd0, w6 = 8'd0, w7 = 8'd0, w8 = 8'd0;
    logic       win_valid = 1'b0;
    logic       win_sof = 1'b0;
    logic [7:0] mag;
    logic       edge_flag, out_valid, out_sof, out_eol, out_eof, frame_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Output monitor state (only the monitor process writes these).
    logic       mon_clr = 1'b0;
    int         mon_cnt, mon_sof, mon_eol, mon_eof, mon_bub;
    int         last_sof, last_eol, last_eof;
    logic [7:0] mon_mag [N];
    logic       mon_edge [N];

    sobel_edge_3x3 #(.IMG_W(W), .IMG_H(H), .THRESH(8'd128)) dut (
        .clk(clk), .rst(rst),
        .win0(w0), .win1(w1), .win2(w2), .win3(w3), .win4(w4),
        .win5(w5), .win6(w6), .win7(w7), .win8(w8),
        .win_valid(win_valid), .win_sof(win_sof),
        .mag(mag), .edge_flag(edge_flag), .out_valid(out_valid),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Record the output stream on the falling edge.
    always @(negedge clk) begin
        if (mon_clr) begin
            mon_cnt = 0; mon_sof = 0; mon_eol = 0; mon_eof = 0; mon_bub = 0;
            last_sof = -1; last_eol = -1; last_eof = -1;
        end else if (out_valid) begin
            if (mon_cnt < N) begin
                mon_mag[mon_cnt]  = mag;
                mon_edge[mon_cnt] = edge_flag;
            end
            if (out_sof) begin mon_sof++; last_sof = mon_cnt; end
            if (out_eol) begin mon_eol++; last_eol = mon_cnt; end
            if (out_eof) begin mon_eof++; last_eof = mon_cnt; end
            mon_cnt++;
        end else if (out_sof || out_eol || out_eof) begin
            mon_bub++;
        end
    end

    function automatic logic [71:0] mkw(input logic [7:0] a0, a1, a2, a3, a4,
                                        a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Frame pattern: win5 = a, win1 = b, rest 0 -> Gx = 2a, Gy = -2b.
    function automatic logic [71:0] pat(input int idx);
        logic [7:0] a, b;
        a = 8'((idx * 7) % 256);
        b = 8'((idx * 3) % 256);
        return mkw(8'd0, b, 8'd0, 8'd0, 8'd0, a, 8'd0, 8'd0, 8'd0);
    endfunction

    function automatic logic [7:0] exp_mag(input int idx);
        int col, row, s;
        col = idx % W;
        row = idx / W;
        if (col == 0 || col == W - 1 || row == 0 || row == H - 1) return 8'd0;
        s = 2 * ((idx * 7) % 256) + 2 * ((idx * 3) % 256);
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    task automatic drive(input logic [71:0] wp, input logic v, input logic s);
        {w8, w7, w6, w5, w4, w3, w2, w1, w0} = wp;
        win_valid = v;
        win_sof   = s;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(72'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic clear_mon();
        win_valid = 1'b0;
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (mag !== 8'd0) $display("FAIL reset_mag got %0d want 0", mag); else pass_cnt++;
        total_cnt++; if (edge_flag !== 1'b0) $display("FAIL reset_edge got %b want 0", edge_flag); else pass_cnt++;
        total_cnt++; if ({out_sof, out_eol, out_eof} !== 3'b000) $display("FAIL reset_markers got %b want 000", {out_sof, out_eol, out_eof}); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else pass_cnt++;
    endtask

    // Interior windows at (1,1)..(6,1), each followed by bubbles.
    task automatic test_interior();
        logic [71:0] tw [6];
        logic [7:0]  tm [6];
        logic        te [6];
        tw[0] = mkw(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100); tm[0] = 8'd0;   te[0] = 1'b0;
        tw[1] = mkw(8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255);           tm[1] = 8'd255; te[1] = 1'b1;
        tw[2] = mkw(8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd40, 8'd10, 8'd10, 8'd10);        tm[2] = 8'd60;  te[2] = 1'b0;
        tw[3] = mkw(8'd200, 8'd200, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);           tm[3] = 8'd255; te[3] = 1'b1;
        tw[4] = mkw(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd63, 8'd0, 8'd0, 8'd0);                tm[4] = 8'd126; te[4] = 1'b0;
        tw[5] = mkw(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd0);                tm[5] = 8'd128; te[5] = 1'b1;
        do_reset();
        drive(72'd0, 1'b1, 1'b1);
        for (int i = 0; i < W; i++) drive(72'd0, 1'b1, 1'b0);
        idle(4);
        for (int k = 0; k < 6; k++) begin
            drive(tw[k], 1'b1, 1'b0);
            idle(1);
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL interior%0d_early_valid got %b want 0", k, out_valid); else pass_cnt++;
            idle(1);
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL interior%0d_valid got %b want 1", k, out_valid); else pass_cnt++;
            total_cnt++; if (mag !== tm[k]) $display("FAIL interior%0d_mag got %0d want %0d", k, mag, tm[k]); else pass_cnt++;
            total_cnt++; if (edge_flag !== te[k]) $display("FAIL interior%0d_edge got %b want %b", k, edge_flag, te[k]); else pass_cnt++;
            total_cnt++; if ({out_sof, out_eol, out_eof} !== 3'b000) $display("FAIL interior%0d_markers got %b want 000", k, {out_sof, out_eol, out_eof}); else pass_cnt++;
        end
    endtask

    // Frame stream checks shared by the continuous and toggled runs.
    task automatic check_frame(input string tag);
        int bad_mag, bad_edge, first_bad;
        bad_mag = 0; bad_edge = 0; first_bad = -1;
        total_cnt++; if (mon_cnt !== N) $display("FAIL %s_count got %0d want %0d", tag, mon_cnt, N); else pass_cnt++;
        total_cnt++; if (mon_sof !== 1 || last_sof !== 0) $display("FAIL %s_sof got %0d@%0d want 1@0", tag, mon_sof, last_sof); else pass_cnt++;
        total_cnt++; if (mon_eol !== H || last_eol !== N - 1) $display("FAIL %s_eol got %0d last@%0d want %0d last@%0d", tag, mon_eol, last_eol, H, N - 1); else pass_cnt++;
        total_cnt++; if (mon_eof !== 1 || last_eof !== N - 1) $display("FAIL %s_eof got %0d@%0d want 1@%0d", tag, mon_eof, last_eof, N - 1); else pass_cnt++;
        total_cnt++; if (mon_bub !== 0) $display("FAIL %s_bubble_markers got %0d want 0", tag, mon_bub); else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            if (mon_mag[i] !== exp_mag(i)) begin
                bad_mag++;
                if (first_bad < 0) first_bad = i;
            end
            if (mon_edge[i] !== (exp_mag(i) >= 8'd128)) bad_edge++;
        end
        total_cnt++; if (bad_mag !== 0) $display("FAIL %s_mag_seq got %0d bad (first @%0d) want 0", tag, bad_mag, first_bad); else pass_cnt++;
        total_cnt++; if (bad_edge !== 0) $display("FAIL %s_edge_seq got %0d bad want 0", tag, bad_edge); else pass_cnt++;
    endtask

    task automatic test_full_frame();
        do_reset();
        clear_mon();
        for (int i = 0; i < N; i++) drive(pat(i), 1'b1, (i == 0));
        idle(4);
        check_frame("full");
        drive(pat(70), 1'b1, 1'b0);
        idle(4);
        total_cnt++; if (mon_cnt !== N) $display("FAIL full_back_to_idle got %0d outputs want %0d", mon_cnt, N); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_mon();
        for (int i = 0; i < N; i++) begin
            drive(pat(i), 1'b1, (i == 0));
            drive(pat(i + 1), 1'b0, 1'b0);
        end
        idle(4);
        check_frame("toggle");
    endtask

    task automatic test_sof_restart();
        do_reset();
        clear_mon();
        for (int i = 0; i < 3; i++) drive(pat(i + 100), 1'b1, 1'b0);
        idle(4);
        total_cnt++; if (mon_cnt !== 0) $display("FAIL pre_sof_dropped got %0d outputs want 0", mon_cnt); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL pre_sof_frame_err got %b want 0", frame_err); else pass_cnt++;
        for (int i = 0; i < 2 * W + 5; i++) drive(pat(i), 1'b1, (i == 0));
        drive(pat(0), 1'b1, 1'b1);
        total_cnt++; if (frame_err !== 1'b1) $display("FAIL restart_frame_err got %b want 1", frame_err); else pass_cnt++;
        for (int j = 1; j < W; j++) drive(pat(j), 1'b1, 1'b0);
        idle(4);
        total_cnt++; if (mon_sof !== 2 || last_sof !== 2 * W + 5) $display("FAIL restart_sof got %0d@%0d want 2@%0d", mon_sof, last_sof, 2 * W + 5); else pass_cnt++;
        total_cnt++; if (mon_eol !== 3 || last_eol !== 3 * W + 4) $display("FAIL restart_eol got %0d last@%0d want 3 last@%0d", mon_eol, last_eol, 3 * W + 4); else pass_cnt++;
    endtask

    // Continues the restarted frame from test_sof_restart (frame_err set).
    task automatic test_reset_mid_frame();
        int base;
        for (int i = 0; i < 3; i++) drive(pat(i + W), 1'b1, 1'b0);
        rst = 1'b1;
        drive(pat(W + 3), 1'b1, 1'b0);
        rst = 1'b0;
        total_cnt++; if ({out_valid, edge_flag, out_sof, out_eol, out_eof} !== 5'b00000) $display("FAIL rst_mid_outputs got %b want 00000", {out_valid, edge_flag, out_sof, out_eol, out_eof}); else pass_cnt++;
        total_cnt++; if (mag !== 8'd0) $display("FAIL rst_mid_mag got %0d want 0", mag); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL rst_mid_frame_err got %b want 0", frame_err); else pass_cnt++;
        base = mon_cnt;
        for (int i = 0; i < 3; i++) drive(pat(i + W + 4), 1'b1, 1'b0);
        idle(4);
        total_cnt++; if (mon_cnt !== base) $display("FAIL rst_mid_ignored got %0d outputs want %0d", mon_cnt, base); else pass_cnt++;
        drive(pat(1), 1'b1, 1'b1);
        idle(2);
        total_cnt++; if ({out_valid, out_sof} !== 2'b11) $display("FAIL rst_mid_new_sof got %b want 11", {out_valid, out_sof}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_interior();
        test_full_frame();
        test_back_to_back();
        test_sof_restart();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
